// File: rtl/fifo_drain_scheduler_if.sv
// Handshake bundle between the FIFO bank, the drain scheduler and the downstream consumer.
// master = scheduler side, slave = FIFO bank / consumer side.
interface fifo_drain_scheduler_if #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 8
);
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    logic                   enable;
    logic [NUM_Q-1:0]       q_valid;
    logic [NUM_Q*WIDTH-1:0] q_data;
    logic [NUM_Q-1:0]       q_ren;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [QW-1:0]          out_qid;
    logic                   out_ready;

    modport master (
        input  enable, q_valid, q_data, out_ready,
        output q_ren, out_valid, out_data, out_qid
    );

    modport slave (
        output enable, q_valid, q_data, out_ready,
        input  q_ren, out_valid, out_data, out_qid
    );
endinterface

// File: rtl/fifo_drain_scheduler.sv
// Round-robin drain of NUM_Q FWFT FIFOs into one registered valid/ready slot,
// with a per-queue burst limit before the grant rotates.
module fifo_drain_scheduler #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_drain_scheduler_if.master bus
);
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    logic [QW-1:0]    cur;
    logic [CW-1:0]    burst_cnt;

    logic             load_p0;
    logic             gnt_p0;
    logic             stay_p0;
    logic             found_p0;
    logic [QW-1:0]    cand_p0;
    logic [QW-1:0]    sel_p0;
    logic [WIDTH-1:0] head_p0;
    logic [NUM_Q-1:0] ren_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [QW-1:0]    qid_p1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= BURST_C) ? BURST_C : c + CW'(1);
    endfunction

    // ---- stage p0: grant selection (combinational, pops the FIFO this cycle)
    always_comb begin
        load_p0  = !vld_p1 || bus.out_ready;
        gnt_p0   = load_p0 && bus.enable && (|bus.q_valid) && !rst;
        stay_p0  = bus.q_valid[cur] && (burst_cnt != '0) && (burst_cnt < BURST_C);
        sel_p0   = cur;
        found_p0 = 1'b0;
        cand_p0  = '0;
        if (!stay_p0) begin
            // cur is visited last, so an exhausted burst re-grants it only when alone
            for (int k = 1; k <= NUM_Q; k++) begin
                cand_p0 = QW'((int'(cur) + k) % NUM_Q);
                if (!found_p0 && bus.q_valid[cand_p0]) begin
                    sel_p0   = cand_p0;
                    found_p0 = 1'b1;
                end
            end
        end
        head_p0 = bus.q_data[int'(sel_p0)*WIDTH +: WIDTH];
        ren_p0  = '0;
        if (gnt_p0) ren_p0[sel_p0] = 1'b1;
    end

    // ---- stage p1: output slot and arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            qid_p1    <= '0;
            cur       <= QW'(NUM_Q - 1);
            burst_cnt <= '0;
        end else begin
            if (load_p0) vld_p1 <= gnt_p0;
            if (gnt_p0) begin
                data_p1 <= head_p0;
                qid_p1  <= sel_p0;
                if (stay_p0) begin
                    burst_cnt <= sat_inc(burst_cnt);
                end else begin
                    cur       <= sel_p0;
                    burst_cnt <= CW'(1);
                end
            end
        end
    end

    assign bus.q_ren     = ren_p0;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_qid   = qid_p1;
endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Directed bench for fifo_drain_scheduler: FIFO models feed the DUT, a grant model
// predicts q_ren and a scoreboard holds the words expected out of the slot.
module tb_fifo_drain_scheduler;
    localparam int NUM_Q = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_drain_scheduler_if #(.NUM_Q(NUM_Q), .WIDTH(WIDTH)) bus ();

    fifo_drain_scheduler #(.NUM_Q(NUM_Q), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] fq [NUM_Q][$];
    logic [NUM_Q-1:0] qmask;

    int m_cur;
    int m_cnt;
    bit m_vld;

    int               sb_qid [$];
    logic [WIDTH-1:0] sb_dat [$];

    bit               rec;
    int               seen_qid [$];
    logic [WIDTH-1:0] seen_dat [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        logic [NUM_Q-1:0]       v;
        logic [NUM_Q*WIDTH-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (qmask[i] && fq[i].size() > 0) begin
                v[i] = 1'b1;
                d[i*WIDTH +: WIDTH] = fq[i][0];
            end
        end
        bus.q_valid = v;
        bus.q_data  = d;
    endtask

    function automatic int pick(output bit stay);
        stay = 1'b0;
        if (!(bus.enable && (!m_vld || bus.out_ready) && (|bus.q_valid))) return -1;
        if (bus.q_valid[m_cur] && m_cnt > 0 && m_cnt < BURST) begin
            stay = 1'b1;
            return m_cur;
        end
        for (int k = 1; k <= NUM_Q; k++) begin
            int j;
            j = (m_cur + k) % NUM_Q;
            if (bus.q_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = NUM_Q - 1;
        m_cnt = 0;
        m_vld = 1'b0;
        sb_qid.delete();
        sb_dat.delete();
    endtask

    // One clock: called just after a rising edge, returns just after the next one.
    task automatic tick();
        int               g;
        bit               stay;
        bit               load;
        logic [WIDTH-1:0] head;
        drive_inputs();
        #1;
        chk("out_valid", bus.out_valid, m_vld);
        if (m_vld && sb_qid.size() > 0) begin
            chk("out_data", bus.out_data, sb_dat[0]);
            chk("out_qid", bus.out_qid, sb_qid[0]);
            if (bus.out_ready) begin
                if (rec) begin
                    seen_qid.push_back(sb_qid[0]);
                    seen_dat.push_back(sb_dat[0]);
                end
                void'(sb_qid.pop_front());
                void'(sb_dat.pop_front());
            end
        end
        load = !m_vld || bus.out_ready;
        g = pick(stay);
        chk("q_ren", bus.q_ren, (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        #1;
        if (load) m_vld = (g >= 0);
        if (g >= 0) begin
            head = fq[g][0];
            void'(fq[g].pop_front());
            sb_qid.push_back(g);
            sb_dat.push_back(head);
            if (stay) begin
                m_cnt++;
            end else begin
                m_cur = g;
                m_cnt = 1;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_Q; i++) fq[i].delete();
        drive_inputs();
        rst = 1'b1;
        #1;
        chk("rst_ren", bus.q_ren, 0);
        chk("rst_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp4 [10];
        exp4 = '{1, 1, 2, 2, 2, 2, 3, 3, 2, 2};
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        qmask         = '1;
        rec           = 1'b0;
        model_reset();

        // Reset state, with a queue already valid so the forced-low q_ren is visible
        fq[2].push_back(8'hA1);
        fq[2].push_back(8'hB2);
        fq[2].push_back(8'hC3);
        drive_inputs();
        #2;
        chk("init_ren", bus.q_ren, 0);
        chk("init_valid", bus.out_valid, 0);
        chk("init_data", bus.out_data, 0);
        chk("init_qid", bus.out_qid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single queue, three heads popped back to back
        rec = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_inputs();
            #1;
            chk("t1_ren", bus.q_ren, 4'b0100);
            tick();
        end
        repeat (3) tick();
        rec = 1'b0;
        chk("t1_count", seen_dat.size(), 3);
        if (seen_dat.size() == 3) begin
            chk("t1_d0", seen_dat[0], 8'hA1);
            chk("t1_d1", seen_dat[1], 8'hB2);
            chk("t1_d2", seen_dat[2], 8'hC3);
            for (int k = 0; k < 3; k++) chk("t1_qid", seen_qid[k], 2);
        end
        chk("t1_idle", bus.out_valid, 0);

        // 2: all queues valid, burst-limited rotation at full rate
        do_reset();
        for (int q = 0; q < NUM_Q; q++)
            for (int k = 0; k < 6; k++) fq[q].push_back(8'(q * 16 + k));
        seen_qid.delete();
        seen_dat.delete();
        rec = 1'b1;
        repeat (18) tick();
        rec = 1'b0;
        chk("t2_count", seen_qid.size(), 17);
        if (seen_qid.size() == 17)
            for (int k = 0; k < 17; k++) chk("t2_seq", seen_qid[k], (k < 16) ? k / 4 : 0);

        // 3: backpressure holds the slot, then enable drops
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        repeat (2) tick();
        bus.enable = 1'b0;
        drive_inputs();
        #1;
        chk("t3_en_ren", bus.q_ren, 0);
        repeat (2) tick();
        chk("t3_drained", bus.out_valid, 0);
        bus.enable = 1'b1;

        // 4: queue 1 empties mid-burst, queue 2 takes a full burst, then rotation
        do_reset();
        repeat (2) fq[1].push_back(8'h11);
        for (int k = 0; k < 6; k++) fq[2].push_back(8'(8'h20 + k));
        repeat (2) fq[3].push_back(8'h33);
        seen_qid.delete();
        seen_dat.delete();
        rec = 1'b1;
        repeat (11) tick();
        rec = 1'b0;
        chk("t4_count", seen_qid.size(), 10);
        if (seen_qid.size() == 10)
            for (int k = 0; k < 10; k++) chk("t4_seq", seen_qid[k], exp4[k]);

        // 5: lone queue re-granted without bubbles across burst boundaries
        do_reset();
        for (int k = 0; k < 10; k++) fq[0].push_back(8'(8'h50 + k));
        for (int c = 0; c < 10; c++) begin
            drive_inputs();
            #1;
            chk("t5_ren", bus.q_ren, 4'b0001);
            tick();
        end
        repeat (2) tick();

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        repeat (4) fq[1].push_back(8'h61);
        repeat (4) fq[3].push_back(8'h63);
        repeat (2) tick();
        drive_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", bus.out_valid, 0);
        chk("t6_async_ren", bus.q_ren, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_inputs();
        #1;
        chk("t6_first_ren", bus.q_ren, 4'b0010);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
